// File: rtl/vdp_pkg.sv
// Shared line buffer types for the pixel-clock reader: word layout,
// pixel slicing helper and reader FSM states.
package vdp_pkg;

    localparam int LB_PIXEL_W         = 9;
    localparam int LB_PIXELS_PER_WORD = 8;
    localparam int LB_WORD_W          = LB_PIXEL_W * LB_PIXELS_PER_WORD;

    // Pixel i of a word occupies bits [9*i+8 : 9*i]; pixel 0 is shown first.
    typedef logic [LB_PIXELS_PER_WORD-1:0][LB_PIXEL_W-1:0] lb_word_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        STREAM   = 2'd2
    } lb_reader_state_t;

    // Select one palette index out of a buffered word.
    function automatic logic [LB_PIXEL_W-1:0] lb_pixel(input lb_word_t word,
                                                       input logic [2:0] idx);
        return word[idx];
    endfunction

endpackage

// File: rtl/lb_word_fifo.sv
// Two-entry word FIFO between the line buffer read port and the pixel
// serializer. Flush has priority over push/pop so a new line starts empty.
module lb_word_fifo
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  lb_word_t   push_data,
    input  logic       pop,
    output lb_word_t   head,
    output logic [1:0] count
);

    lb_word_t mem [0:1];
    logic     wr_ptr;
    logic     rd_ptr;

    assign head = mem[rd_ptr];

    // Storage, pointers and occupancy; the reader never pushes when full
    // or pops when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/line_buffer_reader.sv
// Pixel-clock side reader of the 72-bit line buffer. Prefetches two words
// ahead of the beam, serializes one palette index per active pixel and
// optionally zeroes each word behind the read pointer.
//
// Read port handshake: lb_rd_en/lb_rd_addr are registered; the RAM returns
// lb_rd_data exactly one cycle after the cycle in which lb_rd_en is high.
// Every read carries the line generation it was issued under, and data
// returning under a stale generation (after an aborting line_start) is
// dropped instead of being pushed into the FIFO.
module line_buffer_reader
    import vdp_pkg::*;
#(
    parameter int                    WORDS_PER_LINE = 80,
    parameter int                    ADDR_W         = 9,
    parameter logic [LB_PIXEL_W-1:0] BG_COLOUR      = 9'd0,
    parameter bit                    CLEAR_EN       = 1'b1
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    input  logic                  line_start,
    input  logic                  de,
    output logic                  lb_rd_en,
    output logic [ADDR_W-1:0]     lb_rd_addr,
    input  logic [LB_WORD_W-1:0]  lb_rd_data,
    output logic [7:0]            lb_clr_we,
    output logic [ADDR_W-1:0]     lb_clr_addr,
    output logic [LB_PIXEL_W-1:0] colour,
    output logic                  colour_valid,
    output logic                  underrun
);

    localparam int               CNT_W = $clog2(WORDS_PER_LINE + 1);
    localparam logic [CNT_W-1:0] WPL_C = CNT_W'(WORDS_PER_LINE);

    lb_reader_state_t      state;
    logic                  gen;
    logic                  rd_tag;
    logic                  pend;
    logic                  pend_tag;
    logic [CNT_W-1:0]      words_issued;
    logic [CNT_W-1:0]      words_popped;
    logic [2:0]            pix_cnt;

    lb_word_t              fifo_head;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  push;
    logic                  rd_live;
    logic                  consume;
    logic                  pop;
    logic [2:0]            occupancy;
    logic [2:0]            limit;
    logic                  more_words;
    logic                  issue;
    logic [LB_PIXEL_W-1:0] colour_next;

    lb_word_fifo u_fifo (
        .clk       (clk_pix),
        .rst       (rst_pix),
        .flush     (line_start),
        .push      (push),
        .push_data (lb_rd_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Consumption, FIFO budget (entries plus live in-flight reads) and next pixel.
    always_comb begin
        fifo_empty  = (fifo_count == 2'd0);
        push        = pend && (pend_tag == gen);
        rd_live     = lb_rd_en && (rd_tag == gen);
        consume     = (state == STREAM) && de && !fifo_empty;
        pop         = consume && (pix_cnt == 3'd7) && !line_start;
        occupancy   = {1'b0, fifo_count} + {2'b00, rd_live} + {2'b00, push};
        limit       = 3'd2 + {2'b00, pop};
        more_words  = (words_issued < WPL_C);
        issue       = 1'b0;
        if (state == PREFETCH) begin
            issue = more_words;
        end else if (state == STREAM) begin
            issue = more_words && (occupancy < limit);
        end
        colour_next = '0;
        if (de) begin
            colour_next = consume ? lb_pixel(fifo_head, pix_cnt) : BG_COLOUR;
        end
    end

    // Reader FSM with registered read strobe, pixel output and underrun flag.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state        <= IDLE;
            gen          <= 1'b0;
            rd_tag       <= 1'b0;
            pend         <= 1'b0;
            pend_tag     <= 1'b0;
            words_issued <= '0;
            words_popped <= '0;
            pix_cnt      <= 3'd0;
            lb_rd_en     <= 1'b0;
            lb_rd_addr   <= '0;
            colour       <= '0;
            colour_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            lb_rd_en     <= 1'b0;
            pend         <= lb_rd_en;
            pend_tag     <= rd_tag;
            colour       <= colour_next;
            colour_valid <= de;
            if (line_start) begin
                // Abort whatever was running and fetch word 0 immediately.
                state        <= PREFETCH;
                gen          <= ~gen;
                rd_tag       <= ~gen;
                lb_rd_en     <= 1'b1;
                lb_rd_addr   <= '0;
                words_issued <= CNT_W'(1);
                words_popped <= '0;
                pix_cnt      <= 3'd0;
                underrun     <= 1'b0;
            end else begin
                if (de && fifo_empty && (state != IDLE)) begin
                    underrun <= 1'b1;
                end
                if (consume) begin
                    pix_cnt <= pix_cnt + 3'd1;
                end
                if (pop) begin
                    words_popped <= words_popped + CNT_W'(1);
                end
                if (issue) begin
                    lb_rd_en     <= 1'b1;
                    lb_rd_addr   <= lb_rd_addr + ADDR_W'(1);
                    rd_tag       <= gen;
                    words_issued <= words_issued + CNT_W'(1);
                end
                case (state)
                    PREFETCH: state <= STREAM;
                    STREAM: begin
                        if (pop && (words_popped == WPL_C - CNT_W'(1))) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    // Zero the popped word one cycle after it leaves the FIFO; a pending
    // clear is not cancelled by line_start.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            lb_clr_we   <= 8'h00;
            lb_clr_addr <= '0;
        end else if (CLEAR_EN && pop) begin
            lb_clr_we   <= 8'hFF;
            lb_clr_addr <= ADDR_W'(words_popped);
        end else begin
            lb_clr_we   <= 8'h00;
        end
    end

endmodule

// File: tb/tb_line_buffer_reader.sv
// Directed bench for line_buffer_reader: behavioural line buffer RAM,
// pixel scoreboard and read/clear address logs.
module tb_line_buffer_reader;

    localparam int         WPL = 80;
    localparam int         AW  = 9;
    localparam logic [8:0] BG  = 9'h1A5;

    logic          clk;
    logic          rst_pix;
    logic          line_start;
    logic          de;
    logic          lb_rd_en;
    logic [AW-1:0] lb_rd_addr;
    logic [71:0]   lb_rd_data;
    logic [7:0]    lb_clr_we;
    logic [AW-1:0] lb_clr_addr;
    logic [8:0]    colour;
    logic          colour_valid;
    logic          underrun;

    int            checks;
    int            failures;
    int            pix_seen;
    bit            occ_chk;
    logic          de_d;
    logic [8:0]    exp_q[$];
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] clr_log[$];
    logic [71:0]   mem [0:511];

    line_buffer_reader #(
        .WORDS_PER_LINE (WPL),
        .ADDR_W         (AW),
        .BG_COLOUR      (BG),
        .CLEAR_EN       (1'b1)
    ) u_dut (
        .clk_pix      (clk),
        .rst_pix      (rst_pix),
        .line_start   (line_start),
        .de           (de),
        .lb_rd_en     (lb_rd_en),
        .lb_rd_addr   (lb_rd_addr),
        .lb_rd_data   (lb_rd_data),
        .lb_clr_we    (lb_clr_we),
        .lb_clr_addr  (lb_clr_addr),
        .colour       (colour),
        .colour_valid (colour_valid),
        .underrun     (underrun)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // line buffer RAM: data one cycle after the strobe; clears are only logged
    always @(posedge clk) begin
        if (lb_rd_en) lb_rd_data <= mem[lb_rd_addr];
    end

    // de as the DUT should have registered it
    always @(posedge clk or posedge rst_pix) begin
        if (rst_pix) de_d <= 1'b0;
        else         de_d <= de;
    end

    function automatic logic [8:0] pix_val(input int w, input int p);
        return 9'(((w * 8 + p) % 511) + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        rd_log.delete();
        clr_log.delete();
        pix_seen = 0;
    endtask

    task automatic drive_pixels(input int n, input int first, input bit gapped);
        for (int k = 0; k < n; k++) begin
            de = 1'b1;
            exp_q.push_back(pix_val((first + k) / 8, (first + k) % 8));
            tick();
            if (gapped) begin
                de = 1'b0;
                tick();
            end
        end
        de = 1'b0;
    endtask

    task automatic check_rd_log(input int n);
        check("rd_count", 32'(rd_log.size()), 32'(n));
        for (int i = 0; i < n && i < rd_log.size(); i++) begin
            check("rd_addr", 32'(rd_log[i]), 32'(i));
        end
    endtask

    task automatic check_clr_log(input int n);
        check("clr_count", 32'(clr_log.size()), 32'(n));
        for (int i = 0; i < n && i < clr_log.size(); i++) begin
            check("clr_addr", 32'(clr_log[i]), 32'(i));
        end
    endtask

    // scoreboard and port monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!rst_pix) begin
            if (lb_rd_en) rd_log.push_back(lb_rd_addr);
            if (lb_clr_we != 8'h00) begin
                check("clr_mask", 32'(lb_clr_we), 32'hFF);
                clr_log.push_back(lb_clr_addr);
            end
            check("colour_valid", 32'(colour_valid), 32'(de_d));
            if (de_d) begin
                check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("colour", 32'(colour), 32'(exp));
                end
                if (colour_valid) pix_seen++;
            end else begin
                check("colour_idle", 32'(colour), 32'd0);
            end
            if (occ_chk) begin
                check("fifo_bound", 32'((rd_log.size() - pix_seen / 8) <= 2), 32'd1);
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        pix_seen   = 0;
        occ_chk    = 1'b0;
        rst_pix    = 1'b0;
        line_start = 1'b0;
        de         = 1'b0;
        for (int w = 0; w < 512; w++) begin
            for (int p = 0; p < 8; p++) begin
                mem[w][9*p +: 9] = pix_val(w, p);
            end
        end

        // reset state
        #1 rst_pix = 1'b1;
        repeat (3) tick();
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_cv", 32'(colour_valid), 32'd0);
        check("rst_rd_en", 32'(lb_rd_en), 32'd0);
        check("rst_clr_we", 32'(lb_clr_we), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst_pix = 1'b0;
        repeat (3) tick();

        // two words, continuous de
        pulse_line_start();
        repeat (4) tick();
        drive_pixels(16, 0, 1'b0);
        repeat (4) tick();
        check_rd_log(4);
        check_clr_log(2);
        check("a_underrun", 32'(underrun), 32'd0);

        // gapped de
        pulse_line_start();
        repeat (4) tick();
        occ_chk = 1'b1;
        drive_pixels(16, 0, 1'b1);
        repeat (4) tick();
        occ_chk = 1'b0;
        check_rd_log(4);
        check_clr_log(2);
        check("d_underrun", 32'(underrun), 32'd0);

        // abort at pixel 20
        pulse_line_start();
        repeat (4) tick();
        drive_pixels(20, 0, 1'b0);
        pulse_line_start();
        repeat (4) tick();
        drive_pixels(16, 0, 1'b0);
        repeat (4) tick();
        check_rd_log(4);
        check("e1_underrun", 32'(underrun), 32'd0);

        // abort while the read of word 2 is in flight
        pulse_line_start();
        repeat (4) tick();
        drive_pixels(8, 0, 1'b0);
        pulse_line_start();
        repeat (4) tick();
        drive_pixels(16, 0, 1'b0);
        repeat (4) tick();
        check_rd_log(4);
        check_clr_log(2);

        // de straight after line_start
        pulse_line_start();
        de = 1'b1;
        exp_q.push_back(BG);
        tick();
        de = 1'b0;
        tick();
        check("c_underrun_set", 32'(underrun), 32'd1);
        pulse_line_start();
        check("c_underrun_clr", 32'(underrun), 32'd0);

        // full line plus one extra de
        repeat (4) tick();
        drive_pixels(WPL * 8, 0, 1'b0);
        de = 1'b1;
        exp_q.push_back(BG);
        tick();
        de = 1'b0;
        repeat (4) tick();
        check("b_underrun", 32'(underrun), 32'd0);
        check_rd_log(WPL);
        check_clr_log(WPL);

        // asynchronous reset mid-stream, right after word 0 pops
        pulse_line_start();
        repeat (4) tick();
        drive_pixels(8, 0, 1'b0);
        check("pre_rst_cv", 32'(colour_valid), 32'd1);
        check("pre_rst_clr_we", 32'(lb_clr_we), 32'hFF);
        check("pre_rst_rd_en", 32'(lb_rd_en), 32'd1);
        #2 rst_pix = 1'b1;
        #1;
        check("mid_rst_colour", 32'(colour), 32'd0);
        check("mid_rst_cv", 32'(colour_valid), 32'd0);
        check("mid_rst_rd_en", 32'(lb_rd_en), 32'd0);
        check("mid_rst_clr_we", 32'(lb_clr_we), 32'd0);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        exp_q.delete();
        rd_log.delete();
        clr_log.delete();
        repeat (2) tick();
        rst_pix = 1'b0;
        repeat (10) tick();
        check("post_rst_reads", 32'(rd_log.size()), 32'd0);
        check("post_rst_clears", 32'(clr_log.size()), 32'd0);
        check("post_rst_cv", 32'(colour_valid), 32'd0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
